// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - one-hot ring-counter sequence decoder with lock tracking
// Optional saturating violation counter enabled by RING_DECODER_ERRCNT_EN.
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int IDXW     = 2,
  parameter int LOCK_CNT = 2,
  parameter int DIR      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [IDXW-1:0]  idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev_word, prev_nxt, rot_prev;
  logic [3:0]       cnt, cnt_nxt, cnt_inc;
  logic [4:0]       ones;
  logic [IDXW-1:0]  enc;
  logic             valid, match, err_nxt;

  always_comb begin
    ones = '0;
    enc  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        ones = ones + 5'd1;
        enc  = IDXW'(i);
      end
    end
  end

  generate
    if (DIR == 0) begin : g_rot_left
      assign rot_prev = {prev_word[WIDTH-2:0], prev_word[WIDTH-1]};
    end else begin : g_rot_right
      assign rot_prev = {prev_word[0], prev_word[WIDTH-1:1]};
    end
  endgenerate

  assign valid   = (ones == 5'd1);
  assign match   = valid && (in == rot_prev);
  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev_word;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    if (en) begin
      case (state)
        SEEK: begin
          if (valid) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
            prev_nxt  = in;
          end
        end
        TRACK: begin
          if (!valid) begin
            state_nxt = SEEK;
            cnt_nxt   = '0;
          end else if (match) begin
            prev_nxt = in;
            cnt_nxt  = cnt_inc;
            if (cnt_inc == 4'(LOCK_CNT)) state_nxt = LOCKED;
          end else begin
            cnt_nxt  = '0;
            prev_nxt = in;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_nxt = in;
          end else begin
            // a held word also lands here since it never equals its own rotation
            err_nxt = 1'b1;
            cnt_nxt = '0;
            if (valid) begin
              state_nxt = TRACK;
              prev_nxt  = in;
            end else begin
              state_nxt = SEEK;
            end
          end
        end
        default: begin
          state_nxt = SEEK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEEK;
      prev_word <= '0;
      cnt       <= '0;
      idx       <= '0;
      onehot_ok <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_word <= prev_nxt;
      cnt       <= cnt_nxt;
      locked    <= (state_nxt == LOCKED);
      err       <= err_nxt;
      if (en) begin
        onehot_ok <= valid;
        if (valid) idx <= enc;
      end
    end
  end

`ifdef RING_DECODER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (err_nxt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - directed self-checking bench for ring_decoder
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] in_w;
  logic [1:0] idx;
  logic       onehot_ok;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RING_DECODER_ERRCNT_EN
  localparam logic [7:0] EXP_ONE = 8'd1;
  localparam logic [7:0] EXP_SAT = 8'd255;
`else
  localparam logic [7:0] EXP_ONE = 8'd0;
  localparam logic [7:0] EXP_SAT = 8'd0;
`endif

  ring_decoder #(.WIDTH(4), .IDXW(2), .LOCK_CNT(2), .DIR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in_w),
    .idx       (idx),
    .onehot_ok (onehot_ok),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [3:0] v);
    in_w = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    en    = 1'b0;
    in_w  = 4'b0000;
    #2;
    n_checks++; if (idx !== 2'd0)        begin n_fail++; $display("FAIL reset_idx got %0d exp 0", idx); end
    n_checks++; if (onehot_ok !== 1'b0)  begin n_fail++; $display("FAIL reset_onehot got %0b exp 0", onehot_ok); end
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL reset_locked got %0b exp 0", locked); end
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %0b exp 0", err); end
    n_checks++; if (err_cnt !== 8'd0)    begin n_fail++; $display("FAIL reset_errcnt got %0d exp 0", err_cnt); end
    @(posedge clk); #1;
    reset = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_sequence;
    logic [3:0] words [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] eidx  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       elock [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(words[i]);
      n_checks++; if (idx !== eidx[i])      begin n_fail++; $display("FAIL seq_idx[%0d] got %0d exp %0d", i, idx, eidx[i]); end
      n_checks++; if (locked !== elock[i])  begin n_fail++; $display("FAIL seq_locked[%0d] got %0b exp %0b", i, locked, elock[i]); end
      n_checks++; if (err !== 1'b0)         begin n_fail++; $display("FAIL seq_err[%0d] got %0b exp 0", i, err); end
      n_checks++; if (onehot_ok !== 1'b1)   begin n_fail++; $display("FAIL seq_onehot[%0d] got %0b exp 1", i, onehot_ok); end
    end
  endtask

  task automatic test_err_track;
    apply(4'b0100); apply(4'b1000); apply(4'b0001);
    n_checks++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL trk_prelock got %0b exp 1", locked); end
    apply(4'b0100);
    n_checks++; if (err !== 1'b1)        begin n_fail++; $display("FAIL trk_err got %0b exp 1", err); end
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL trk_unlock got %0b exp 0", locked); end
    n_checks++; if (err_cnt !== EXP_ONE) begin n_fail++; $display("FAIL trk_errcnt got %0d exp %0d", err_cnt, EXP_ONE); end
    n_checks++; if (idx !== 2'd2)        begin n_fail++; $display("FAIL trk_idx got %0d exp 2", idx); end
    apply(4'b1000);
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL trk_errpulse got %0b exp 0", err); end
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL trk_cnt1 got %0b exp 0", locked); end
    apply(4'b0001);
    n_checks++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL trk_relock got %0b exp 1", locked); end
  endtask

  task automatic test_invalid;
    apply(4'b0110);
    n_checks++; if (onehot_ok !== 1'b0)  begin n_fail++; $display("FAIL inv_onehot got %0b exp 0", onehot_ok); end
    n_checks++; if (err !== 1'b1)        begin n_fail++; $display("FAIL inv_err got %0b exp 1", err); end
    n_checks++; if (idx !== 2'd0)        begin n_fail++; $display("FAIL inv_idx got %0d exp 0", idx); end
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL inv_locked got %0b exp 0", locked); end
    apply(4'b0001);
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL inv_err2 got %0b exp 0", err); end
    n_checks++; if (onehot_ok !== 1'b1)  begin n_fail++; $display("FAIL inv_onehot2 got %0b exp 1", onehot_ok); end
    apply(4'b0010);
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL inv_seek got %0b exp 0", locked); end
    apply(4'b0100);
    n_checks++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL inv_relock got %0b exp 1", locked); end
    n_checks++; if (idx !== 2'd2)        begin n_fail++; $display("FAIL inv_idx2 got %0d exp 2", idx); end
  endtask

  task automatic test_async_reset;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL ar_locked got %0b exp 0", locked); end
    n_checks++; if (idx !== 2'd0)        begin n_fail++; $display("FAIL ar_idx got %0d exp 0", idx); end
    n_checks++; if (err_cnt !== 8'd0)    begin n_fail++; $display("FAIL ar_errcnt got %0d exp 0", err_cnt); end
    n_checks++; if (onehot_ok !== 1'b0)  begin n_fail++; $display("FAIL ar_onehot got %0b exp 0", onehot_ok); end
    #2;
    reset = 1'b1;
    apply(4'b0010);
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL ar_s1 got %0b exp 0", locked); end
    apply(4'b0100);
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL ar_s2 got %0b exp 0", locked); end
    apply(4'b1000);
    n_checks++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL ar_s3 got %0b exp 1", locked); end
  endtask

  task automatic test_en_hold;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(4'b0110);
      n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL en_err[%0d] got %0b exp 0", i, err); end
      n_checks++; if (locked !== 1'b1)    begin n_fail++; $display("FAIL en_locked[%0d] got %0b exp 1", i, locked); end
      n_checks++; if (idx !== 2'd3)       begin n_fail++; $display("FAIL en_idx[%0d] got %0d exp 3", i, idx); end
      n_checks++; if (onehot_ok !== 1'b1) begin n_fail++; $display("FAIL en_onehot[%0d] got %0b exp 1", i, onehot_ok); end
    end
    en = 1'b1;
    apply(4'b0001);
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL en_resume_err got %0b exp 0", err); end
    n_checks++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL en_resume_locked got %0b exp 1", locked); end
    n_checks++; if (idx !== 2'd0)        begin n_fail++; $display("FAIL en_resume_idx got %0d exp 0", idx); end
  endtask

  task automatic test_err_sat;
    int errs_seen = 0;
    for (int i = 0; i < 300; i++) begin
      apply(4'b0001); apply(4'b0010); apply(4'b0100);
      apply(4'b0100);
      if (err === 1'b1) errs_seen++;
    end
    n_checks++; if (errs_seen !== 300)   begin n_fail++; $display("FAIL sat_pulses got %0d exp 300", errs_seen); end
    n_checks++; if (err_cnt !== EXP_SAT) begin n_fail++; $display("FAIL sat_cnt got %0d exp %0d", err_cnt, EXP_SAT); end
    apply(4'b1000); apply(4'b0001);
    n_checks++; if (locked !== 1'b1)     begin n_fail++; $display("FAIL sat_lock got %0b exp 1", locked); end
    apply(4'b0001);
    n_checks++; if (err !== 1'b1)        begin n_fail++; $display("FAIL sat_held_err got %0b exp 1", err); end
    n_checks++; if (err_cnt !== EXP_SAT) begin n_fail++; $display("FAIL sat_hold got %0d exp %0d", err_cnt, EXP_SAT); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_err_track();
    test_invalid();
    test_async_reset();
    test_en_hold();
    test_err_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
